// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: per-channel event stretcher (IDLE/ON/GAP) with a
// shared PWM dimmer. Turns single-cycle strobes into visible LED blinks.
module led_pulse_stretcher #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned HOLD_CYCLES = 2500000,
  parameter int unsigned GAP_CYCLES  = 1250000,
  parameter int unsigned RETRIGGER   = 0,
  parameter int unsigned PWM_BITS    = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [NCH-1:0]      i_event,
  input  logic [PWM_BITS-1:0] i_brightness,
  output logic [NCH-1:0]      o_led,
  output logic [NCH-1:0]      o_busy
);

  localparam int unsigned MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_C  = (MAX_HG > 2) ? MAX_HG : 2;
  localparam int unsigned TW     = $clog2(MAX_C);

  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic RETRIG = (RETRIGGER != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            r_state     [NCH];
  state_t            w_state_nxt [NCH];
  logic [TW-1:0]     r_timer     [NCH];
  logic [TW-1:0]     w_timer_nxt [NCH];
  logic [NCH-1:0]    r_pend;
  logic [NCH-1:0]    w_pend_nxt;
  logic [NCH-1:0]    w_led_nxt;
  logic [NCH-1:0]    w_busy_nxt;

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_lat;
  logic [PWM_BITS-1:0] w_cnt_nxt;
  logic [PWM_BITS-1:0] w_lat_nxt;
  logic                w_pwm_on_nxt;

  // PWM next state: the latch follows the counter into 0 so each period
  // uses one consistent brightness; the LED is driven from the next values.
  always_comb begin
    w_cnt_nxt    = (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
    w_lat_nxt    = (w_cnt_nxt == '0) ? i_brightness : r_lat;
    w_pwm_on_nxt = (w_cnt_nxt < w_lat_nxt);
  end

  // PWM counter and brightness latch
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
      r_lat <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_lat <= w_lat_nxt;
    end
  end

  // Channel state register plus registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned n = 0; n < NCH; n++) begin
        r_state[n] <= S_IDLE;
        r_timer[n] <= '0;
      end
      r_pend <= '0;
      o_led  <= '0;
      o_busy <= '0;
    end else begin
      for (int unsigned n = 0; n < NCH; n++) begin
        r_state[n] <= w_state_nxt[n];
        r_timer[n] <= w_timer_nxt[n];
      end
      r_pend <= w_pend_nxt;
      o_led  <= w_led_nxt;
      o_busy <= w_busy_nxt;
    end
  end

  // Channel next-state: hold timer, optional gap, one queued blink
  always_comb begin
    w_pend_nxt = r_pend;
    for (int unsigned n = 0; n < NCH; n++) begin
      w_state_nxt[n] = r_state[n];
      w_timer_nxt[n] = r_timer[n];
      case (r_state[n])
        S_IDLE: begin
          if (i_event[n]) begin
            w_state_nxt[n] = S_ON;
            w_timer_nxt[n] = HOLD_LD;
            w_pend_nxt[n]  = 1'b0;
          end
        end
        S_ON: begin
          if (RETRIG && i_event[n]) begin
            w_timer_nxt[n] = HOLD_LD;
          end else if (r_timer[n] == '0) begin
            if (GAP_CYCLES > 0) begin
              w_state_nxt[n] = S_GAP;
              w_timer_nxt[n] = GAP_LD;
              w_pend_nxt[n]  = r_pend[n] | i_event[n];
            end else if (r_pend[n] | i_event[n]) begin
              // zero gap: the gap-exit decision happens on this same edge
              w_state_nxt[n] = S_ON;
              w_timer_nxt[n] = HOLD_LD;
              w_pend_nxt[n]  = 1'b0;
            end else begin
              w_state_nxt[n] = S_IDLE;
              w_timer_nxt[n] = '0;
              w_pend_nxt[n]  = 1'b0;
            end
          end else begin
            w_timer_nxt[n] = r_timer[n] - 1'b1;
            w_pend_nxt[n]  = r_pend[n] | (i_event[n] & ~RETRIG);
          end
        end
        S_GAP: begin
          if (r_timer[n] == '0) begin
            if (r_pend[n] | i_event[n]) begin
              w_state_nxt[n] = S_ON;
              w_timer_nxt[n] = HOLD_LD;
            end else begin
              w_state_nxt[n] = S_IDLE;
              w_timer_nxt[n] = '0;
            end
            w_pend_nxt[n] = 1'b0;
          end else begin
            w_timer_nxt[n] = r_timer[n] - 1'b1;
            w_pend_nxt[n]  = r_pend[n] | i_event[n];
          end
        end
        default: begin
          w_state_nxt[n] = S_IDLE;
          w_timer_nxt[n] = '0;
          w_pend_nxt[n]  = 1'b0;
        end
      endcase
    end
  end

  // Output decode from next state (registered in the state block)
  always_comb begin
    w_led_nxt  = '0;
    w_busy_nxt = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      w_led_nxt[n]  = (w_state_nxt[n] == S_ON) && w_pwm_on_nxt;
      w_busy_nxt[n] = (w_state_nxt[n] != S_IDLE);
    end
  end

endmodule

// File: doc/led_pulse_stretcher.md
Name: led_pulse_stretcher

Overview:
- Output-side counterpart of the button input conditioning. The input path turns slow, noisy human events into clean logic levels; this block turns fast, single-cycle logic events into human-visible LED blinks.
- NCH independent channels. Each channel stretches an event to a fixed on-time and then enforces a minimum off-gap, so back-to-back events show as separate blinks.
- A shared PWM stage dims all LEDs.
- Sits between status/strobe sources (UART activity, CPU traps, debounced buttons) and the board LED pins.

Parameters:
- NCH, 4, number of independent channels.
- HOLD_CYCLES, 2500000, LED on-time per event in clocks; must be ≥1.
- GAP_CYCLES, 1250000, minimum LED off-time between blinks in clocks; 0 allowed (no gap).
- RETRIGGER, 0, 0 = event during on-time queues one further blink; 1 = event during on-time reloads the hold timer.
- PWM_BITS, 4, brightness resolution; PWM period is 2^PWM_BITS−1 clocks.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_event  in  NCH  per-channel event; sampled high on any clock edge = one event; synchronous to i_clk.
- i_brightness  in  PWM_BITS  duty numerator; 0 = off, 2^PWM_BITS−1 = fully on.
- o_led  out  NCH  registered LED drive, active high.
- o_busy  out  NCH  channel not IDLE (ON or GAP); registered.

Behaviour:
- Reset (asynchronous, i_reset_n low):
  - All channels to IDLE; timers 0; pending flags 0.
  - PWM counter 0; brightness latch 0.
  - o_led = 0, o_busy = 0. Takes effect immediately.
  - Deassertion mid-blink restarts everything from IDLE.
- Per-channel FSM, states IDLE / ON / GAP:
  - Timer width is $clog2(max(HOLD_CYCLES, GAP_CYCLES, 2)).
  - IDLE + event: go to ON, timer = HOLD_CYCLES−1, pending = 0.
  - In ON:
    - Timer decrements each clock.
    - Event with RETRIGGER=1: timer reloads to HOLD_CYCLES−1.
    - Event with RETRIGGER=0: pending = 1. Only one blink is queued; further events are absorbed.
  - ON with timer==0 and no reload:
    - If GAP_CYCLES>0: go to GAP, timer = GAP_CYCLES−1.
    - If GAP_CYCLES==0: treat as the GAP-exit decision in the same edge.
  - In GAP: event sets pending = 1; timer decrements.
  - GAP with timer==0:
    - pending (or an event in this cycle): go to ON, timer = HOLD_CYCLES−1, pending = 0.
    - otherwise: go to IDLE.
  - Event in the final ON cycle:
    - RETRIGGER=1: reload, stay ON.
    - RETRIGGER=0: pending is set and honoured after the gap.
- Timing:
  - An event sampled at edge k gives ON from edge k onward.
  - ON lasts exactly HOLD_CYCLES clocks; GAP lasts exactly GAP_CYCLES clocks.
  - o_busy is high for every non-IDLE cycle.
- PWM:
  - Free-running counter cycles 0..2^PWM_BITS−2 and wraps to 0.
  - i_brightness is latched only when the counter is 0.
  - pwm_on = counter < latch.
  - The first period after reset is dark, since the latch resets to 0.
- LED output:
  - o_led[n] is registered from next-state: o_led[n] <= (next_state==ON) && next_pwm_on.
  - At full brightness, o_led rises at edge k and stays high exactly HOLD_CYCLES clocks.
- Channels are fully independent. Simultaneous events on several channels are all accepted.
- No combinational path from input to output.

Test Plan:
Common setup unless stated: HOLD_CYCLES=4, GAP_CYCLES=3, PWM_BITS=2 (period 3), i_brightness=3 held steady through the first PWM period.
- Single event, RETRIGGER=0: pulse i_event[0] one cycle at edge k -> o_led[0]=1 for edges k..k+3; o_busy[0]=1 for 7 clocks; then IDLE, o_led=0.
- Queued blink, RETRIGGER=0: events at k and k+2 -> LED high 4, low 3, high 4, then IDLE; a third event at k+3 is absorbed (no third blink).
- Retrigger, RETRIGGER=1: events at k and k+3 (the final ON cycle) -> LED high continuously for 7 clocks, then GAP 3, then IDLE.
- PWM: i_brightness=1, hold channel 1 ON via RETRIGGER=1 and repeated events -> o_led[1] pattern 1,0,0 repeating. Brightness changed mid-period is applied only from the next counter==0. i_brightness=0 -> o_led constantly 0 while o_busy=1.
- Reset mid-operation: assert i_reset_n=0 during ON of all 4 channels -> o_led=0 and o_busy=0 immediately, without waiting for a clock. After release, no blink occurs until a new event.
- Gap edge case, GAP_CYCLES=0: events at k and k+3 with RETRIGGER=0 -> LED high 8 consecutive clocks (pending honoured on the same edge), then IDLE.
